// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. The block owns the program counter and keeps at
// most one instruction-memory request in flight. Each returned word is held in
// an instruction register together with the PC it came from until decode
// takes it. Branch resolution can redirect the PC at any time. Any response
// that belongs to the old instruction stream is then discarded.
//
// The opcode, funct3 and funct7 fields are plain slices of the instruction
// register. ALU control uses them directly, so they only change on the edge
// that loads a new instruction.
//
// Parameters
//   RESET_PC         first fetch address after reset (bits [1:0] must be 0)
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   imem_req_valid   request valid (fetch FSM is issuing)
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    fetch address, always equal to the PC register
//   imem_resp_valid  response word valid (only honoured while waiting)
//   imem_resp_data   instruction word from memory
//   redirect_valid   single-cycle taken branch/jump pulse
//   redirect_pc      redirect target (bits [1:0] are ignored)
//   inst_valid       instruction register holds a word for decode
//   inst_ready       decode accepts the instruction this cycle
//   inst             instruction register
//   inst_pc          PC of the word in the instruction register
//   opcode           inst[6:0]
//   funct3           inst[14:12]
//   funct7           inst[31:25]
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } state_t;

  // The reset value of the instruction register is a NOP (addi x0, x0, 0).
  // Until the first real fetch, ALU control therefore sees a harmless
  // decode.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic [31:0] redirect_tgt;

  // Instructions are word aligned, so the low address bits of a target are
  // cleared rather than trusted.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end
        if (imem_req_ready) begin
          // A request that is accepted together with a redirect still fetches
          // the old PC. Its response has to be thrown away.
          state_d = WAIT;
          drop_d  = redirect_valid;
        end
      end

      WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            pc_d = redirect_tgt;
          end
          if (drop_q || redirect_valid) begin
            // The word belongs to a stream that has been redirected away.
            // Refetch from the current PC.
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
            state_d   = FULL;
          end
        end else if (redirect_valid) begin
          // The request is still in flight. Remember to discard its response.
          pc_d   = redirect_tgt;
          drop_d = 1'b1;
        end
      end

      FULL: begin
        if (redirect_valid) begin
          // Flush. The instruction register keeps its stale contents but is
          // never presented, because inst_valid is masked this cycle.
          pc_d    = redirect_tgt;
          state_d = REQ;
        end else if (inst_ready) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;

  // This is the only combinational input-to-output path. A redirect kills the
  // decode handshake in the same cycle.
  assign inst_valid = (state_q == FULL) && !redirect_valid;

  assign inst    = inst_q;
  assign inst_pc = inst_pc_q;
  assign opcode  = inst_q[6:0];
  assign funct3  = inst_q[14:12];
  assign funct7  = inst_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. An instruction memory model in the bench answers each
// accepted request after a programmable latency with word = addr ^ 32'h33.
// A transaction-level reference tracks one number: the address the next
// useful fetch must come from. Every accepted request must target that
// address. Every instruction decode takes must be that address and its
// memory word. A delivery advances the address by 4. A redirect replaces it.
// A fixed vector table covers the start-up stream and the decode stall. Hand
// sequences cover redirects, wrap-around and mid-fetch reset. A long random
// run stresses everything against the reference.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .opcode          (opcode),
    .funct3          (funct3),
    .funct7          (funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model state: 0 = never ready, 1 = always ready, 2 = random ready.
  int          mem_mode;
  int          mem_k;
  bit          pending;
  bit          stale;
  logic [31:0] paddr;
  int          cnt;

  // Reference: address of the next instruction the stream must deliver.
  logic [31:0] exp_addr;
  int          deliveries;

  typedef struct {
    bit          irdy;
    bit          exp_rv;
    logic [31:0] exp_ra;
    bit          exp_iv;
    logic [31:0] exp_ipc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_0033;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"},  imem_req_addr, RST_PC);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"},      inst, 32'h0000_0013);
    chk({tag, "_inst_pc"},   inst_pc, 32'd0);
    chk({tag, "_opcode"},    32'(opcode), 32'h13);
    chk({tag, "_funct3"},    32'(funct3), 32'd0);
    chk({tag, "_funct7"},    32'(funct7), 32'd0);
  endtask

  // One clock cycle: drive inputs on the falling edge, let them settle, then
  // check this cycle's handshakes against the reference. Outputs stay
  // readable for the caller until the next call.
  task automatic tick(input bit irdy, input bit rdv, input logic [31:0] rpc);
    logic [31:0] w;
    @(negedge clk);
    inst_ready     = irdy;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    imem_req_ready = (mem_mode == 1) || ((mem_mode == 2) && ($urandom_range(0, 2) != 0));
    if (pending && cnt > 0) cnt--;
    if (pending && cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(paddr);
      pending         = 1'b0;
      stale           = 1'b0;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom();
    end
    #1;
    if (!rst_n) begin
      exp_addr = RST_PC;
      if (pending) stale = 1'b1;
    end else begin
      if (pending && !stale) chk("req_while_busy", 32'(imem_req_valid), 32'd0);
      if (inst_valid && inst_ready) begin
        w = mem_word(exp_addr);
        chk("dlv_pc",     inst_pc, exp_addr);
        chk("dlv_inst",   inst, w);
        chk("dlv_opcode", 32'(opcode), 32'(w[6:0]));
        chk("dlv_funct3", 32'(funct3), 32'(w[14:12]));
        chk("dlv_funct7", 32'(funct7), 32'(w[31:25]));
        exp_addr = exp_addr + 32'd4;
        deliveries++;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_addr);
        pending = 1'b1;
        paddr   = imem_req_addr;
        cnt     = mem_k;
      end
      if (redirect_valid) begin
        chk("redirect_masks_valid", 32'(inst_valid), 32'd0);
        exp_addr = redirect_pc & 32'hFFFF_FFFC;
      end
    end
  endtask

  initial begin
    bit          ir;
    bit          rd;
    logic [31:0] tgt;
    int          rand_base;

    // Start-up stream with k=1, followed by a 5-cycle decode stall.
    tbl[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h000, 32'h013};
    tbl[1]  = '{1'b1, 1'b0, 32'h100, 1'b0, 32'h000, 32'h013};
    tbl[2]  = '{1'b1, 1'b0, 32'h104, 1'b1, 32'h100, 32'h133};
    tbl[3]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h100, 32'h133};
    tbl[4]  = '{1'b1, 1'b0, 32'h104, 1'b0, 32'h100, 32'h133};
    tbl[5]  = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h104, 32'h137};
    tbl[6]  = '{1'b1, 1'b1, 32'h108, 1'b0, 32'h104, 32'h137};
    tbl[7]  = '{1'b1, 1'b0, 32'h108, 1'b0, 32'h104, 32'h137};
    tbl[8]  = '{1'b1, 1'b0, 32'h10C, 1'b1, 32'h108, 32'h13B};
    tbl[9]  = '{1'b1, 1'b1, 32'h10C, 1'b0, 32'h108, 32'h13B};
    tbl[10] = '{1'b1, 1'b0, 32'h10C, 1'b0, 32'h108, 32'h13B};
    for (int i = 11; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 32'h110, 1'b1, 32'h10C, 32'h13F};
    tbl[16] = '{1'b1, 1'b0, 32'h110, 1'b1, 32'h10C, 32'h13F};
    tbl[17] = '{1'b1, 1'b1, 32'h110, 1'b0, 32'h10C, 32'h13F};

    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    inst_ready      = 1'b0;
    mem_mode        = 1;
    mem_k           = 1;
    pending         = 1'b0;
    stale           = 1'b0;
    paddr           = 32'd0;
    cnt             = 0;
    exp_addr        = RST_PC;
    deliveries      = 0;

    repeat (3) @(negedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].irdy, 1'b0, 32'd0);
      chk($sformatf("vec%0d_req_valid", i),  32'(imem_req_valid), 32'(tbl[i].exp_rv));
      chk($sformatf("vec%0d_req_addr", i),   imem_req_addr, tbl[i].exp_ra);
      chk($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].exp_iv));
      chk($sformatf("vec%0d_inst_pc", i),    inst_pc, tbl[i].exp_ipc);
      chk($sformatf("vec%0d_inst", i),       inst, tbl[i].exp_inst);
    end

    // Redirect while waiting; the late response must be dropped.
    mem_k = 4;
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    chk("wait_redir_prev_pc", inst_pc, 32'h110);
    tick(1'b1, 1'b0, 32'd0);
    chk("wait_redir_req_addr", imem_req_addr, 32'h114);
    tick(1'b1, 1'b1, 32'h200);
    chk("wait_redir_iv", 32'(inst_valid), 32'd0);
    mem_k = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 32'd0);
      chk("drop_iv", 32'(inst_valid), 32'd0);
      chk("drop_no_req", 32'(imem_req_valid), 32'd0);
    end
    tick(1'b1, 1'b0, 32'd0);
    chk("after_drop_req_valid", 32'(imem_req_valid), 32'd1);
    chk("after_drop_req_addr", imem_req_addr, 32'h200);
    tick(1'b1, 1'b0, 32'd0);

    // Redirect in FULL with decode ready: no transfer, target aligned.
    tick(1'b1, 1'b1, 32'h303);
    chk("full_redir_iv", 32'(inst_valid), 32'd0);
    chk("full_redir_inst_pc", inst_pc, 32'h200);
    tick(1'b1, 1'b0, 32'd0);
    chk("full_redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("full_redir_req_addr", imem_req_addr, 32'h300);
    chk("full_redir_stale_inst", inst, 32'h233);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    chk("full_redir_new_pc", inst_pc, 32'h300);
    chk("full_redir_new_inst", inst, 32'h333);

    // Redirect coinciding with acceptance, then a fetch at the top of memory.
    tick(1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("req_redir_addr_old", imem_req_addr, 32'h304);
    tick(1'b1, 1'b0, 32'd0);
    chk("req_redir_drop_iv", 32'(inst_valid), 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_pc", imem_req_addr, 32'h0000_0000);
    mem_k = 5;
    tick(1'b1, 1'b0, 32'd0);
    chk("wrap_next_req_valid", 32'(imem_req_valid), 32'd1);
    chk("wrap_next_req_addr", imem_req_addr, 32'h0000_0000);

    // Reset while waiting; the late response must be ignored.
    tick(1'b1, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    mem_mode = 0;
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    rst_n = 1'b1;
    mem_k = 1;
    tick(1'b1, 1'b0, 32'd0);
    chk("postrst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("postrst_req_addr", imem_req_addr, RST_PC);
    tick(1'b1, 1'b0, 32'd0);
    chk("stale_resp_iv", 32'(inst_valid), 32'd0);
    chk("stale_resp_req_valid", 32'(imem_req_valid), 32'd1);
    chk("stale_resp_inst", inst, 32'h0000_0013);
    mem_mode = 1;
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    chk("postrst_inst_pc", inst_pc, RST_PC);
    chk("postrst_inst", inst, 32'h133);

    // Random traffic against the reference.
    mem_mode  = 2;
    rand_base = deliveries;
    for (int i = 0; i < 3000; i++) begin
      mem_k = $urandom_range(1, 4);
      ir    = ($urandom_range(0, 3) != 0);
      rd    = ($urandom_range(0, 9) == 0);
      tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
      tick(ir, rd, tgt);
    end
    chk("random_progress", 32'((deliveries - rand_base) > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the core: owns the program counter, issues one instruction-memory request at a time, and presents each fetched instruction with its PC to decode. It sits directly upstream of ALU control. The instruction fields opcode, funct3 and funct7 are sliced from its output register and drive the ALU control inputs without further logic. It takes PC redirects from branch resolution; a taken BEQ is resolved by the ALU's SUB result.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk  in  1  rising-edge clock; the block has one clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address (= pc)
- imem_resp_valid  in  1  response data valid; one response per accepted request, earliest 1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump taken, single-cycle pulse
- redirect_pc  in  32  redirect target
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction register
- inst_pc  out  32  PC of inst
- opcode  out  7  inst[6:0]
- funct3  out  3  inst[14:12]
- funct7  out  7  inst[31:25]

## Operation
- Registers:
  - pc (32)
  - state: IDLE, REQ, WAIT, FULL
  - drop (1)
  - inst (32)
  - inst_pc (32)
- Reset values:
  - state=IDLE, pc=RESET_PC, drop=0
  - inst=32'h0000_0013 (NOP; opcode=7'b0010011, funct3=0, funct7=0)
  - inst_pc=0
  - outputs: imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC
- Combinational outputs:
  - imem_req_valid = (state==REQ)
  - imem_req_addr = pc
  - inst_valid = (state==FULL) && !redirect_valid
- IDLE: always goes to REQ on the next edge.
- REQ:
  - Accepted request (imem_req_ready=1) -> WAIT.
  - redirect_valid=1 -> pc<=redirect_pc with bits [1:0] forced to 0.
  - redirect_valid together with acceptance -> WAIT with drop<=1.
  - redirect_valid without acceptance -> stay in REQ.
- WAIT:
  - On imem_resp_valid with drop=1 -> discard data, drop<=0, go to REQ.
  - On imem_resp_valid with drop=0 and no redirect -> inst<=imem_resp_data, inst_pc<=pc, pc<=pc+4, go to FULL.
  - redirect_valid with no response -> pc<=redirect_pc, drop<=1, stay in WAIT.
  - redirect_valid with imem_resp_valid in the same cycle -> discard data, pc<=redirect_pc, drop unchanged (0), go to REQ.
- FULL:
  - inst_valid && inst_ready -> go to REQ.
  - redirect_valid -> flush: the handshake that cycle is void (inst_valid is masked), pc<=redirect_pc, go to REQ. inst keeps its stale value.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- At most one request is outstanding; imem_resp_valid outside WAIT is a protocol error and is ignored.
- Asserting rst_n low mid-operation returns every register to its reset value immediately. Any response pending at that point is ignored, because reset leaves state=IDLE and responses are only taken in WAIT.

## Timing
- First request: imem_req_valid=1 in the first cycle after the first rising edge at which rst_n is sampled high.
- Request accepted in cycle N, response in cycle N+k (k>=1):
  - inst_valid=1 from cycle N+k+1
  - next request possible in cycle N+k+2 if decode accepts in N+k+1
- Peak throughput with zero-wait memory (k=1): one instruction per 3 cycles.
- The redirect -> inst_valid path is combinational. Every other output is registered or a direct function of the registers.
- opcode, funct3 and funct7 change only on the edge that loads inst.

## Test plan
- Reset with RESET_PC=32'h100, memory always ready, k=1, data = address ^ 32'h33 -> requests at 0x100, 0x104, 0x108. inst_valid asserts every 3rd cycle; inst_pc matches and inst=addr^0x33.
- Hold inst_ready=0 for 5 cycles with inst_valid=1 -> inst, inst_pc and inst_valid stable; no new request issued. Release -> next request follows 1 cycle later.
- Redirect to 32'h200 while in WAIT, response 3 cycles later -> that response is dropped (inst_valid stays 0). The next request is at 0x200.
- Redirect in FULL with inst_ready=1 in the same cycle -> inst_valid=0 that cycle, no transfer. The next request is at the redirect target, with bits [1:0] of redirect_pc=32'h303 cleared to give 0x300.
- Fetch at pc=32'hFFFF_FFFC -> the following request is at 32'h0000_0000.
- Drop rst_n low while in WAIT, then raise it and send a late response -> outputs at reset values; the stale response is ignored; the first request is again at RESET_PC.
